pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_pkg.sv | 29 ++
 rtl/dmem_wait_timer.sv | 31 +++
 rtl/pipeline_control.sv | 128 ++++++++++++
 tb/tb_pipeline_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// rtl/pipeline_control_pkg.sv - shared state encodings and control-word types for pipeline_control
package pipeline_control_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } pc_state_t;

  // One control word covering every stage enable and NOP injection.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // Free-running pipeline: everything advances, nothing squashed.
  localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                  ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0};
  // Safe state used in reset and halt: nothing moves, NOPs everywhere.
  localparam ctrl_t CTRL_SAFE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                                  ifid_flush: 1'b1, idex_bubble: 1'b1, memwb_bubble: 1'b1};

endpackage

// File: rtl/dmem_wait_timer.sv
// rtl/dmem_wait_timer.sv - data-memory wait counter with timeout compare
module dmem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  // Counter only needs to reach TIMEOUT-1; a zero timeout keeps a 1-bit counter.
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt;

  // Clear on wait entry, count each frozen wait cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

  // A zero timeout never expires, so the controller can wait forever.
  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline stall/flush/freeze controller; optional perf counters via PIPE_PERF_CNT_EN
import pipeline_control_pkg::*;

module pipeline_control #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_req,
  input  logic                 branch_taken_ex,
  input  logic                 imem_ready,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 memwb_bubble,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_cycles
);

  pc_state_t state;
  ctrl_t     ctrl;
  logic      mem_freeze;
  logic      branch_flush;
  logic      timer_clear;
  logic      timer_count;
  logic      timer_expired;

  // An outstanding data access that is not completing freezes the whole pipe.
  assign mem_freeze  = ((state == RUN) || (state == MEM_WAIT)) && dmem_req_mem && !dmem_ready;
  assign timer_clear = (state == RUN) && mem_freeze;
  assign timer_count = (state == MEM_WAIT) && mem_freeze;

  dmem_wait_timer #(
    .TIMEOUT (DMEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // Prioritised control decode: reset/halt, freeze, branch, load-use, fetch miss.
  always_comb begin
    ctrl         = CTRL_RUN;
    branch_flush = 1'b0;
    if (rst || (state == HALT) || (state != RUN && state != MEM_WAIT)) begin
      ctrl = CTRL_SAFE;
    end else if (mem_freeze) begin
      ctrl.pc_en        = 1'b0;
      ctrl.ifid_en      = 1'b0;
      ctrl.idex_en      = 1'b0;
      ctrl.exmem_en     = 1'b0;
      ctrl.memwb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
      branch_flush     = 1'b1;
    end else if (stall_req) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else if (!imem_ready) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  // State machine: wait on the data memory, halt on timeout, leave HALT only via reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_freeze) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!mem_freeze)        state <= RUN;
          else if (timer_expired) state <= HALT;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign halted       = !rst && (state == HALT);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;

  // Count held-PC cycles outside HALT and branch-caused fetch flushes; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state != HALT) && !ctrl.pc_en) stall_q <= stall_q + CNT_WIDTH'(1);
      if (branch_flush)                   flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  logic unused_perf;
  assign unused_perf  = branch_flush;
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed self-checking bench for pipeline_control
module tb_pipeline_control;
  import pipeline_control_pkg::*;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected control words {pc,ifid,idex,exmem en, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] E_RUN    = 7'b1111_000;
  localparam logic [6:0] E_SAFE   = 7'b0000_111;
  localparam logic [6:0] E_FREEZE = 7'b0000_001;
  localparam logic [6:0] E_BRANCH = 7'b1111_110;
  localparam logic [6:0] E_STALL  = 7'b0011_010;
  localparam logic [6:0] E_IMISS  = 7'b0111_100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, stall_req = 1'b0, branch_taken_ex = 1'b0;
  logic imem_ready = 1'b1, dmem_req_mem = 1'b0, dmem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble, halted;
  logic [31:0] stall_cycles, flush_cycles;
  logic nt_pc_en, nt_ifid_en, nt_idex_en, nt_exmem_en, nt_ifid_flush, nt_idex_bubble, nt_memwb_bubble, nt_halted;
  logic [31:0] nt_stall_cycles, nt_flush_cycles;
  logic [6:0] obs;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble};

  pipeline_control #(.DMEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_ex(branch_taken_ex),
    .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .halted(halted), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  pipeline_control #(.DMEM_TIMEOUT(0), .CNT_WIDTH(32)) dut_nt (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_ex(branch_taken_ex),
    .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_en(nt_pc_en), .ifid_en(nt_ifid_en), .idex_en(nt_idex_en), .exmem_en(nt_exmem_en),
    .ifid_flush(nt_ifid_flush), .idex_bubble(nt_idex_bubble), .memwb_bubble(nt_memwb_bubble),
    .halted(nt_halted), .stall_cycles(nt_stall_cycles), .flush_cycles(nt_flush_cycles)
  );

  // Apply one cycle of inputs and move to the sampling point (falling edge).
  task automatic set_in(input logic r, input logic s, input logic b, input logic im,
                        input logic dq, input logic dr);
    rst = r; stall_req = s; branch_taken_ex = b; imem_ready = im;
    dmem_req_mem = dq; dmem_ready = dr;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ecnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic test_reset();
    set_in(1, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 1, 1, 0, 1, 0);
    tests++; if (obs !== E_SAFE) begin fails++; $display("FAIL reset_ctrl got %b want %b", obs, E_SAFE); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
    tests++; if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
    tick();
  endtask

  task automatic test_idle();
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (obs !== E_RUN) begin fails++; $display("FAIL idle_ctrl got %b want %b", obs, E_RUN); end
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL idle_state got %0d want %0d", dut.state, RUN); end
    tick();
  endtask

  task automatic test_stall();
    set_in(0, 1, 0, 1, 0, 0);
    tests++; if (obs !== E_STALL) begin fails++; $display("FAIL stall_ctrl got %b want %b", obs, E_STALL); end
    tick();
    exp_stall++;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (stall_cycles !== ecnt(exp_stall)) begin
      fails++; $display("FAIL stall_count got %0d want %0d", stall_cycles, ecnt(exp_stall)); end
    tick();
  endtask

  task automatic test_branch();
    set_in(0, 1, 1, 1, 0, 0);
    tests++; if (obs !== E_BRANCH) begin fails++; $display("FAIL branch_over_stall got %b want %b", obs, E_BRANCH); end
    tick();
    exp_flush++;
    set_in(0, 0, 1, 0, 0, 0);
    tests++; if (obs !== E_BRANCH) begin fails++; $display("FAIL branch_over_imiss got %b want %b", obs, E_BRANCH); end
    tests++; if (flush_cycles !== ecnt(exp_flush)) begin
      fails++; $display("FAIL branch_flush_count1 got %0d want %0d", flush_cycles, ecnt(exp_flush)); end
    tick();
    exp_flush++;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (flush_cycles !== ecnt(exp_flush) || stall_cycles !== ecnt(exp_stall)) begin
      fails++; $display("FAIL branch_counts got %0d/%0d want %0d/%0d", flush_cycles, stall_cycles,
                        ecnt(exp_flush), ecnt(exp_stall)); end
    tick();
  endtask

  task automatic test_imem_miss();
    set_in(0, 0, 0, 0, 0, 0);
    tests++; if (obs !== E_IMISS) begin fails++; $display("FAIL imiss_ctrl got %b want %b", obs, E_IMISS); end
    tick();
    exp_stall++;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (stall_cycles !== ecnt(exp_stall) || flush_cycles !== ecnt(exp_flush)) begin
      fails++; $display("FAIL imiss_counts got %0d/%0d want %0d/%0d", stall_cycles, flush_cycles,
                        ecnt(exp_stall), ecnt(exp_flush)); end
    tick();
  endtask

  task automatic test_mem_wait();
    set_in(0, 0, 0, 1, 1, 0);
    tests++; if (obs !== E_FREEZE) begin fails++; $display("FAIL memwait_c1 got %b want %b", obs, E_FREEZE); end
    tick();
    set_in(0, 1, 1, 0, 1, 0);
    tests++; if (obs !== E_FREEZE) begin fails++; $display("FAIL memwait_c2_ignores got %b want %b", obs, E_FREEZE); end
    tests++; if (dut.state !== MEM_WAIT) begin fails++; $display("FAIL memwait_state got %0d want %0d", dut.state, MEM_WAIT); end
    tick();
    set_in(0, 0, 0, 1, 1, 0);
    tests++; if (obs !== E_FREEZE) begin fails++; $display("FAIL memwait_c3 got %b want %b", obs, E_FREEZE); end
    tick();
    set_in(0, 0, 0, 1, 1, 1);
    tests++; if (obs !== E_RUN) begin fails++; $display("FAIL memwait_done got %b want %b", obs, E_RUN); end
    tests++; if (dut.state !== MEM_WAIT) begin fails++; $display("FAIL memwait_done_state got %0d want %0d", dut.state, MEM_WAIT); end
    tick();
    exp_stall += 3;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL memwait_exit got %0d want %0d", dut.state, RUN); end
    tests++; if (stall_cycles !== ecnt(exp_stall) || flush_cycles !== ecnt(exp_flush)) begin
      fails++; $display("FAIL memwait_counts got %0d/%0d want %0d/%0d", stall_cycles, flush_cycles,
                        ecnt(exp_stall), ecnt(exp_flush)); end
    tick();
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 0, 0, 1, 1, 0);
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL timeout_early_halt cycle %0d got %b want 0", k, halted); end
      tick();
    end
    exp_stall += 5;
    set_in(0, 0, 1, 1, 0, 0);
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL timeout_halted got %b want 1", halted); end
    tests++; if (obs !== E_SAFE) begin fails++; $display("FAIL halt_ctrl got %b want %b", obs, E_SAFE); end
    tests++; if (nt_halted !== 1'b0 || dut_nt.state !== MEM_WAIT) begin
      fails++; $display("FAIL no_timeout got halted=%b state=%0d want 0/%0d", nt_halted, dut_nt.state, MEM_WAIT); end
    tick();
    set_in(0, 1, 1, 0, 0, 0);
    tests++; if (halted !== 1'b1 || obs !== E_SAFE) begin
      fails++; $display("FAIL halt_sticky got %b/%b want 1/%b", halted, obs, E_SAFE); end
    tests++; if (stall_cycles !== ecnt(exp_stall) || flush_cycles !== ecnt(exp_flush)) begin
      fails++; $display("FAIL halt_counts got %0d/%0d want %0d/%0d", stall_cycles, flush_cycles,
                        ecnt(exp_stall), ecnt(exp_flush)); end
    tick();
    set_in(1, 0, 0, 1, 1, 0);
    tests++; if (halted !== 1'b0 || obs !== E_SAFE) begin
      fails++; $display("FAIL halt_rst_ctrl got %b/%b want 0/%b", halted, obs, E_SAFE); end
    tick();
    exp_stall = 0;
    exp_flush = 0;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (dut.state !== RUN || halted !== 1'b0 || obs !== E_RUN) begin
      fails++; $display("FAIL halt_release got state=%0d halted=%b ctrl=%b want %0d/0/%b", dut.state, halted, obs, RUN, E_RUN); end
    tests++; if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      fails++; $display("FAIL halt_release_counts got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
    tick();
  endtask

  task automatic test_ready_on_last();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 0, 1, 1, 0);
      tick();
    end
    set_in(0, 0, 1, 1, 1, 1);
    tests++; if (obs !== E_BRANCH) begin fails++; $display("FAIL last_ready_ctrl got %b want %b", obs, E_BRANCH); end
    tick();
    exp_stall += 4;
    exp_flush += 1;
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (halted !== 1'b0 || dut.state !== RUN) begin
      fails++; $display("FAIL last_ready_state got halted=%b state=%0d want 0/%0d", halted, dut.state, RUN); end
    tests++; if (stall_cycles !== ecnt(exp_stall) || flush_cycles !== ecnt(exp_flush)) begin
      fails++; $display("FAIL last_ready_counts got %0d/%0d want %0d/%0d", stall_cycles, flush_cycles,
                        ecnt(exp_stall), ecnt(exp_flush)); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_in(0, 0, 0, 1, 1, 0);
    tick();
    set_in(0, 0, 0, 1, 1, 0);
    tick();
    set_in(1, 0, 0, 1, 1, 0);
    tests++; if (obs !== E_SAFE || halted !== 1'b0) begin
      fails++; $display("FAIL midwait_rst_ctrl got %b/%b want %b/0", obs, halted, E_SAFE); end
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    tests++; if (dut.state !== RUN || dut.u_timer.cnt !== 2'd0) begin
      fails++; $display("FAIL midwait_rst_state got state=%0d cnt=%0d want %0d/0", dut.state, dut.u_timer.cnt, RUN); end
    tests++; if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0 || obs !== E_RUN) begin
      fails++; $display("FAIL midwait_rst_after got %0d/%0d ctrl=%b want 0/0 %b", stall_cycles, flush_cycles, obs, E_RUN); end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_stall();
    test_branch();
    test_imem_miss();
    test_mem_wait();
    test_timeout();
    test_ready_on_last();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
